// File: rtl/game_leds_x_buttons.sv
// ============================================================================
// Module   : game_leds_x_buttons
// Brief    : LED/button memory game: show a pattern, capture toggles, score.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_leds_x_buttons #(
    parameter int WIDTH         = 3,
    parameter int SHOW_CYCLES   = 4,
    parameter int INPUT_CYCLES  = 64,
    parameter int RESULT_CYCLES = 8
) (
    input  logic           osc_clk,
    input  logic           reset_n,
    input  logic [WIDTH:0] button,
    output logic [WIDTH:0] led
);

    localparam int QW      = $clog2(WIDTH + 2);
    localparam int MAX_A   = (SHOW_CYCLES > INPUT_CYCLES) ? SHOW_CYCLES : INPUT_CYCLES;
    localparam int MAX_CYC = (MAX_A > RESULT_CYCLES) ? MAX_A : RESULT_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [15:0]   LFSR_SEED   = 16'hACE1;
    localparam logic [TW-1:0] SHOW_LAST   = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] INPUT_LAST  = TW'(INPUT_CYCLES - 1);
    localparam logic [TW-1:0] RESULT_LAST = TW'(RESULT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SHOW   = 2'd0,
        ST_INPUT  = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [WIDTH:0]  sync1_q, sync2_q, prev_q;
    logic [WIDTH:0]  press_w;
    logic [WIDTH:0]  padrao, padrao_d;
    logic [WIDTH:0]  entrada_usuario, entrada_d;
    logic [QW-1:0]   qtd_digitos_corretos, qtd_d;
    logic [WIDTH:0]  led_q, led_d;
    logic [WIDTH:0]  toggled_w;
    logic [WIDTH:0]  thermo_w;
    logic [QW-1:0]   score_w;

    function automatic logic [QW-1:0] popcount(input logic [WIDTH:0] v);
        logic [QW-1:0] c;
        c = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            c = c + QW'(v[i]);
        end
        return c;
    endfunction

    // Rising edge of the synchronized button level gives a one-cycle press pulse.
    assign press_w   = sync2_q & ~prev_q;
    assign toggled_w = entrada_usuario ^ press_w;
    assign score_w   = popcount(~(padrao ^ toggled_w));
    assign led       = led_q;

    always_comb begin
        thermo_w = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            thermo_w[i] = (i < int'(qtd_digitos_corretos));
        end
    end

    always_comb begin
        lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        padrao_d  = padrao;
        entrada_d = entrada_usuario;
        qtd_d     = qtd_digitos_corretos;
        led_d     = led_q;
        case (state_q)
            ST_SHOW: begin
                led_d = padrao;
                if (timer_q == SHOW_LAST) begin
                    state_d   = ST_INPUT;
                    timer_d   = '0;
                    entrada_d = '0;
                end
            end
            ST_INPUT: begin
                led_d     = entrada_usuario;
                entrada_d = toggled_w;
                if (timer_q == INPUT_LAST) begin
                    state_d = ST_RESULT;
                    timer_d = '0;
                    qtd_d   = score_w;
                end
            end
            ST_RESULT: begin
                led_d = thermo_w;
                if (timer_q == RESULT_LAST) begin
                    state_d  = ST_SHOW;
                    timer_d  = '0;
                    padrao_d = lfsr_q[WIDTH:0];
                end
            end
            default: begin
                state_d = ST_SHOW;
                timer_d = '0;
                led_d   = '0;
            end
        endcase
    end

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q              <= ST_SHOW;
            timer_q              <= '0;
            lfsr_q               <= LFSR_SEED;
            sync1_q              <= '0;
            sync2_q              <= '0;
            prev_q               <= '0;
            padrao               <= LFSR_SEED[WIDTH:0];
            entrada_usuario      <= '0;
            qtd_digitos_corretos <= '0;
            led_q                <= '0;
        end else begin
            state_q              <= state_d;
            timer_q              <= timer_d;
            lfsr_q               <= lfsr_d;
            sync1_q              <= button;
            sync2_q              <= sync1_q;
            prev_q               <= sync2_q;
            padrao               <= padrao_d;
            entrada_usuario      <= entrada_d;
            qtd_digitos_corretos <= qtd_d;
            led_q                <= led_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_game_leds_x_buttons.sv
// ============================================================================
// Module   : tb_game_leds_x_buttons
// Brief    : Directed + randomized rounds checked against a round-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_leds_x_buttons;

    localparam int W   = 3;
    localparam int SH  = 4;
    localparam int INW = 64;
    localparam int RS  = 8;
    localparam int RL  = SH + INW + RS;

    logic         osc_clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W:0]   button  = '0;
    logic [W:0]   led;

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;

    logic [15:0]  m_lfsr;
    logic [15:0]  m_pre;
    logic [W:0]   m_pat;
    logic [W:0]   m_in;
    logic [2:0]   m_qtd;
    logic [W:0]   mask;

    game_leds_x_buttons #(
        .WIDTH(W), .SHOW_CYCLES(SH), .INPUT_CYCLES(INW), .RESULT_CYCLES(RS)
    ) dut (
        .osc_clk(osc_clk),
        .reset_n(reset_n),
        .button (button),
        .led    (led)
    );

    always #5 osc_clk = ~osc_clk;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1: tap exponent e reads bit 16-e.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        int    taps [4] = '{16, 14, 13, 11};
        logic  fb;
        fb = 1'b0;
        foreach (taps[k]) fb = fb ^ s[16 - taps[k]];
        return {fb, s[15:1]};
    endfunction

    function automatic logic [W:0] thermo(input int q);
        logic [7:0] t;
        t = 8'((1 << q) - 1);
        return t[W:0];
    endfunction

    function automatic int ph();
        return (cyc - 1) % RL;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the round-level model, then settle past the edge.
    task automatic step();
        @(posedge osc_clk);
        cyc++;
        m_pre  = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
        if (ph() == SH - 1)       m_in  = '0;
        if (ph() == SH + INW - 1) m_qtd = 3'($countones(~(m_pat ^ m_in)));
        if (ph() == RL - 1)       m_pat = m_pre[W:0];
        #1;
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 2 * RL && ph() != target; k++) step();
        chk("run_to_phase", 16'(ph()), 16'(target));
    endtask

    task automatic press(input logic [W:0] m, input int hold, input bit counts);
        button = m;
        if (counts) m_in = m_in ^ m;
        repeat (hold) step();
        button = '0;
        repeat (3) step();
    endtask

    task automatic random_input();
        int n;
        repeat (2) step();
        n = $urandom_range(1, 4);
        for (int e = 0; e < n; e++) begin
            press(W'($urandom_range(1, (1 << (W + 1)) - 1)), $urandom_range(2, 6), 1'b1);
        end
    endtask

    task automatic model_reset();
        cyc    = 0;
        m_lfsr = 16'hACE1;
        m_pat  = 4'b0001;
        m_in   = '0;
        m_qtd  = '0;
    endtask

    initial begin
        model_reset();
        #7;
        chk("rst_led", 16'(led), 16'h0);
        chk("rst_padrao", 16'(dut.padrao), 16'h1);
        chk("rst_entrada", 16'(dut.entrada_usuario), 16'h0);
        chk("rst_qtd", 16'(dut.qtd_digitos_corretos), 16'h0);
        #5 reset_n = 1'b1;

        for (int i = 0; i < SH; i++) begin
            step();
            chk("show_led_after_reset", 16'(led), 16'h1);
        end
        chk("input_entry_clear", 16'(dut.entrada_usuario), 16'h0);

        // Perfect match on the reset pattern 0001.
        repeat (2) step();
        press(4'b0001, 3, 1'b1);
        run_to(SH + INW - 1);
        chk("perfect_entrada", 16'(dut.entrada_usuario), 16'h1);
        chk("perfect_qtd", 16'(dut.qtd_digitos_corretos), 16'd4);
        step();
        chk("perfect_led", 16'(led), 16'hF);

        // Press during RESULT is ignored.
        press(4'b1000, 3, 1'b0);
        chk("result_press_entrada", 16'(dut.entrada_usuario), 16'h1);
        chk("result_press_qtd", 16'(dut.qtd_digitos_corretos), 16'd4);

        run_to(RL - 1);
        chk("new_round_padrao", 16'(dut.padrao), 16'(m_pat));

        // Press during SHOW is ignored; entrada holds until INPUT entry.
        button = 4'b1000;
        step();
        chk("new_round_led", 16'(led), 16'(m_pat));
        step();
        button = '0;
        step();
        chk("show_press_entrada", 16'(dut.entrada_usuario), 16'h1);
        step();
        chk("input_entry_clear2", 16'(dut.entrada_usuario), 16'h0);

        // Random presses, then asynchronous reset mid-INPUT.
        random_input();
        repeat (2) step();
        chk("midinput_entrada", 16'(dut.entrada_usuario), 16'(m_in));
        #2 reset_n = 1'b0;
        #1;
        chk("async_led", 16'(led), 16'h0);
        chk("async_padrao", 16'(dut.padrao), 16'h1);
        chk("async_entrada", 16'(dut.entrada_usuario), 16'h0);
        chk("async_qtd", 16'(dut.qtd_digitos_corretos), 16'h0);
        model_reset();
        #4 reset_n = 1'b1;
        for (int i = 0; i < SH; i++) begin
            step();
            chk("show_led_after_async", 16'(led), 16'h1);
        end

        // Partial match: toggles on bits 1, 2, 1.
        repeat (5) step();
        button = 4'b0010; m_in = m_in ^ 4'b0010;
        repeat (10) step();
        button = 4'b0100; m_in = m_in ^ 4'b0100;
        repeat (10) step();
        button = 4'b0110; m_in = m_in ^ 4'b0010;
        repeat (10) step();
        button = '0;
        run_to(SH + INW - 1);
        chk("partial_entrada", 16'(dut.entrada_usuario), 16'h4);
        chk("partial_qtd", 16'(dut.qtd_digitos_corretos), 16'd2);
        step();
        chk("partial_led", 16'(led), 16'h3);

        // Randomized rounds against the model.
        for (int r = 0; r < 4; r++) begin
            run_to(RL - 1);
            chk("rand_padrao", 16'(dut.padrao), 16'(m_pat));
            mask = W'($urandom_range(0, (1 << (W + 1)) - 1));
            button = mask;
            step();
            chk("rand_show_led", 16'(led), 16'(m_pat));
            step();
            button = '0;
            run_to(SH - 1);
            chk("rand_entry_clear", 16'(dut.entrada_usuario), 16'h0);
            random_input();
            run_to(SH + INW - 1);
            chk("rand_entrada", 16'(dut.entrada_usuario), 16'(m_in));
            chk("rand_qtd", 16'(dut.qtd_digitos_corretos), 16'(m_qtd));
            step();
            chk("rand_led", 16'(led), 16'(thermo(int'(m_qtd))));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
